rotary_multi: RTL

Parametrised multi-channel rotary/quadrature decoder with an integrated synchroniser and debouncer. Each channel tracks a full four-transition Gray-code detent cycle and maintains a position register with wrap or saturate behaviour. It emits one-cycle direction pulses and an illegal-transition error pulse, and supports a synchronous position preload. It sits between the raw encoder pins and the display/control logic, replacing per-encoder single-channel decoders.

---
 rtl/rotary_multi_pkg.sv | 22 ++
 rtl/rotary_chan.sv | 152 +++++++++++++++
 rtl/rotary_multi.sv | 45 ++++
 3 files changed

// File: rtl/rotary_multi_pkg.sv
// Shared types and helpers for the multi-channel quadrature decoder.
// The detent rest code is 2'b11; states track progress through one Gray cycle.
package rotary_multi_pkg;

    typedef enum logic [2:0] {
        REST = 3'd0,
        CW1  = 3'd1,
        CW2  = 3'd2,
        CW3  = 3'd3,
        CCW1 = 3'd4,
        CCW2 = 3'd5,
        CCW3 = 3'd6
    } rot_state_t;

    localparam logic [1:0] REST_CODE = 2'b11;

    // A Gray-coded encoder can only ever flip one pin at a time.
    function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] cur);
        return (prev ^ cur) == 2'b11;
    endfunction

endpackage

// File: rtl/rotary_chan.sv
// One encoder channel: 2-flop synchroniser, debouncer, detent FSM and position register.
// All outputs are registered; pulses last exactly one clock.
module rotary_chan
    import rotary_multi_pkg::*;
#(
    parameter int POS_W     = 8,
    parameter int POS_MAX   = 2**POS_W-1,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       rotary_in,
    input  logic             load,
    input  logic [POS_W-1:0] load_val,
    output logic [POS_W-1:0] rotary_pos,
    output logic             rot_cw,
    output logic             rot_ccw,
    output logic             rot_err
);

    localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [1:0]       sync1_reg, sync2_reg;
    logic [1:0]       clean_reg, clean_next;
    logic [1:0]       prev_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    rot_state_t       state_reg, state_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic             cw_reg, cw_next;
    logic             ccw_reg, ccw_next;
    logic             err_reg, err_next;
    logic [POS_W-1:0] load_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= REST_CODE;
            sync2_reg <= REST_CODE;
            clean_reg <= REST_CODE;
            prev_reg  <= REST_CODE;
            cnt_reg   <= '0;
            state_reg <= REST;
            pos_reg   <= '0;
            cw_reg    <= 1'b0;
            ccw_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            sync1_reg <= rotary_in;
            sync2_reg <= sync1_reg;
            clean_reg <= clean_next;
            prev_reg  <= clean_reg;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
            pos_reg   <= pos_next;
            cw_reg    <= cw_next;
            ccw_reg   <= ccw_next;
            err_reg   <= err_next;
        end
    end

    // Debouncer: accept a new code only after it has differed from clean long enough.
    always_comb begin
        clean_next = clean_reg;
        cnt_next   = '0;
        if (sync2_reg != clean_reg) begin
            if (cnt_reg == CNT_LAST) begin
                clean_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cw_next    = 1'b0;
        ccw_next   = 1'b0;
        err_next   = 1'b0;
        if (clean_reg != prev_reg) begin
            if (is_illegal(prev_reg, clean_reg)) begin
                state_next = REST;
                err_next   = 1'b1;
            end else begin
                case (state_reg)
                    REST: begin
                        if (clean_reg == 2'b01)      state_next = CW1;
                        else if (clean_reg == 2'b10) state_next = CCW1;
                    end
                    CW1: begin
                        if (clean_reg == 2'b00)      state_next = CW2;
                        else if (clean_reg == 2'b11) state_next = REST;
                    end
                    CW2: begin
                        if (clean_reg == 2'b10)      state_next = CW3;
                        else if (clean_reg == 2'b01) state_next = CW1;
                    end
                    CW3: begin
                        if (clean_reg == 2'b11) begin
                            state_next = REST;
                            cw_next    = 1'b1;
                        end else if (clean_reg == 2'b00) begin
                            state_next = CW2;
                        end
                    end
                    CCW1: begin
                        if (clean_reg == 2'b00)      state_next = CCW2;
                        else if (clean_reg == 2'b11) state_next = REST;
                    end
                    CCW2: begin
                        if (clean_reg == 2'b01)      state_next = CCW3;
                        else if (clean_reg == 2'b10) state_next = CCW1;
                    end
                    CCW3: begin
                        if (clean_reg == 2'b11) begin
                            state_next = REST;
                            ccw_next   = 1'b1;
                        end else if (clean_reg == 2'b00) begin
                            state_next = CCW2;
                        end
                    end
                    default: state_next = REST;
                endcase
            end
        end
    end

    assign load_sat = (load_val > POS_TOP) ? POS_TOP : load_val;

    // Preload wins over a same-cycle count; the pulse itself is unaffected.
    always_comb begin
        pos_next = pos_reg;
        if (load) begin
            pos_next = load_sat;
        end else if (cw_next) begin
            if (pos_reg == POS_TOP) pos_next = (WRAP != 0) ? '0 : POS_TOP;
            else                    pos_next = pos_reg + POS_ONE;
        end else if (ccw_next) begin
            if (pos_reg == '0) pos_next = (WRAP != 0) ? POS_TOP : '0;
            else               pos_next = pos_reg - POS_ONE;
        end
    end

    assign rotary_pos = pos_reg;
    assign rot_cw     = cw_reg;
    assign rot_ccw    = ccw_reg;
    assign rot_err    = err_reg;

endmodule

// File: rtl/rotary_multi.sv
// Multi-channel quadrature decoder: one independent rotary_chan per encoder,
// with ports packed channel-major.
module rotary_multi
    import rotary_multi_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int POS_W     = 8,
    parameter int POS_MAX   = 2**POS_W-1,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*CHANNELS-1:0]     rotary_in,
    input  logic [CHANNELS-1:0]       load,
    input  logic [POS_W-1:0]          load_val,
    output logic [POS_W*CHANNELS-1:0] rotary_pos,
    output logic [CHANNELS-1:0]       rot_cw,
    output logic [CHANNELS-1:0]       rot_ccw,
    output logic [CHANNELS-1:0]       rot_err
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            rotary_chan #(
                .POS_W     (POS_W),
                .POS_MAX   (POS_MAX),
                .WRAP      (WRAP),
                .DB_CYCLES (DB_CYCLES)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .rotary_in  (rotary_in[2*gi +: 2]),
                .load       (load[gi]),
                .load_val   (load_val),
                .rotary_pos (rotary_pos[POS_W*gi +: POS_W]),
                .rot_cw     (rot_cw[gi]),
                .rot_ccw    (rot_ccw[gi]),
                .rot_err    (rot_err[gi])
            );
        end
    endgenerate

endmodule
